// File: rtl/spi_slave_mode.sv
// SPI slave for all four CPOL/CPHA modes: synchronised pins, one-entry TX holding buffer,
// back-to-back words, underrun and frame-error strobes.
//
// state | meaning
// IDLE  | deselected, miso_oe low, waiting for cs_n to fall
// LOAD  | one cycle: shifter takes the holding buffer (or default); CPHA=0 also drives bit 0
// SHIFT | selected; sample edges shift mosi in, drive edges shift miso out
module spi_slave_mode #(
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    LSB_FIRST   = 1'b0,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(8'hFF)
) (
  input  logic                  sysClk,
  input  logic                  reset_n,
  input  logic                  spiClk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_d, cs_d;
  logic                    sclk_s, cs_s, mosi_s;
  logic                    lead_edge, trail_edge, sample_edge, drive_edge;
  logic                    cs_fall, cs_rise;
  logic                    do_load, do_drive, do_sample, do_clear, word_end;
  logic                    buf_full, word_done;
  logic [DATA_WIDTH-1:0]   buf_q, tx_shift, rx_shift, load_word;
  logic [CW-1:0]           bit_cnt;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Sync flops reset to the idle pin levels so release from reset creates no false edge.
  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= CPOL;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spiClk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign load_word   = buf_full ? buf_q : DEFAULT_TX;
  assign tx_ready    = ~buf_full;

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_drive  = 1'b0;
    do_sample = 1'b0;
    do_clear  = 1'b0;
    word_end  = 1'b0;
    if (cs_rise) begin
      state_d  = IDLE;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = LOAD;
        LOAD: begin
          do_load  = 1'b1;
          do_drive = !CPHA;
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            do_sample = 1'b1;
            word_end  = (bit_cnt == CW'(DATA_WIDTH - 1));
            do_load   = word_end;
          end else if (drive_edge) begin
            do_drive = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full  <= 1'b0;
      buf_q     <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      word_done <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Emptying on load comes first so a word accepted in the load cycle refills the buffer.
      if (do_load) buf_full <= 1'b0;
      if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_q    <= tx_data;
      end
      underrun  <= do_load && !buf_full;
      frame_err <= do_clear && (bit_cnt != '0);
      word_done <= word_end;
      rx_valid  <= word_done;
      if (word_done) rx_data <= rx_shift;

      if (do_clear) begin
        miso     <= 1'b0;
        miso_oe  <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else begin
        if (state_q == LOAD) miso_oe <= 1'b1;
        if (do_load && do_drive) begin
          miso     <= first_bit(load_word);
          tx_shift <= shift_out(load_word);
        end else if (do_load) begin
          tx_shift <= load_word;
        end else if (do_drive) begin
          miso     <= first_bit(tx_shift);
          tx_shift <= shift_out(tx_shift);
        end
        if (do_sample) begin
          if (LSB_FIRST) rx_shift <= {mosi_s, rx_shift[DATA_WIDTH-1:1]};
          else           rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
          bit_cnt <= word_end ? '0 : bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Scoreboard bench for spi_slave_mode: three instances (mode 0 W8, mode 3 W8, mode 1 W16 LSB-first)
// share one SPI master; a monitor pops expected RX words whenever rx_valid strobes.
module tb_spi_slave_mode;
  localparam int SS = 2;
  localparam int H  = 8;

  logic        sysClk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk_base = 1'b0, cs_base = 1'b1, mosi_pin = 1'b0;
  logic [15:0] tx_data_tb = '0;
  logic        tx_valid_tb = 1'b0;
  int          sel = 0;

  always #5 sysClk = ~sysClk;

  logic        cs0, cs1, cs2, tv0, tv1, tv2, sclk1;
  logic        miso0, miso1, miso2, oe0, oe1, oe2, txr0, txr1, txr2;
  logic        rxv0, rxv1, rxv2, und0, und1, und2, fe0, fe1, fe2;
  logic [7:0]  rxd0, rxd1;
  logic [15:0] rxd2;

  assign cs0   = (sel == 0) ? cs_base : 1'b1;
  assign cs1   = (sel == 1) ? cs_base : 1'b1;
  assign cs2   = (sel == 2) ? cs_base : 1'b1;
  assign tv0   = tx_valid_tb && (sel == 0);
  assign tv1   = tx_valid_tb && (sel == 1);
  assign tv2   = tx_valid_tb && (sel == 2);
  assign sclk1 = ~sclk_base;

  spi_slave_mode #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0), .SYNC_STAGES(SS)) u_m0 (
    .sysClk(sysClk), .reset_n(reset_n), .spiClk(sclk_base), .cs_n(cs0), .mosi(mosi_pin),
    .miso(miso0), .miso_oe(oe0), .tx_data(tx_data_tb[7:0]), .tx_valid(tv0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_valid(rxv0), .underrun(und0), .frame_err(fe0));

  spi_slave_mode #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0), .SYNC_STAGES(SS)) u_m3 (
    .sysClk(sysClk), .reset_n(reset_n), .spiClk(sclk1), .cs_n(cs1), .mosi(mosi_pin),
    .miso(miso1), .miso_oe(oe1), .tx_data(tx_data_tb[7:0]), .tx_valid(tv1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_valid(rxv1), .underrun(und1), .frame_err(fe1));

  spi_slave_mode #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1), .SYNC_STAGES(SS)) u_m1 (
    .sysClk(sysClk), .reset_n(reset_n), .spiClk(sclk_base), .cs_n(cs2), .mosi(mosi_pin),
    .miso(miso2), .miso_oe(oe2), .tx_data(tx_data_tb), .tx_valid(tv2), .tx_ready(txr2),
    .rx_data(rxd2), .rx_valid(rxv2), .underrun(und2), .frame_err(fe2));

  logic        miso_m, oe_m, txr_m, rxv_m, und_m, fe_m;
  logic [15:0] rxd_m;

  always_comb begin
    miso_m = miso0; oe_m = oe0; txr_m = txr0; rxv_m = rxv0; und_m = und0; fe_m = fe0;
    rxd_m  = {8'h00, rxd0};
    if (sel == 1) begin
      miso_m = miso1; oe_m = oe1; txr_m = txr1; rxv_m = rxv1; und_m = und1; fe_m = fe1;
      rxd_m  = {8'h00, rxd1};
    end else if (sel == 2) begin
      miso_m = miso2; oe_m = oe2; txr_m = txr2; rxv_m = rxv2; und_m = und2; fe_m = fe2;
      rxd_m  = rxd2;
    end
  end

  int          cfg_w[3]    = '{8, 8, 16};
  bit          cfg_cpha[3] = '{1'b0, 1'b1, 1'b1};
  bit          cfg_lsb[3]  = '{1'b0, 1'b0, 1'b1};
  logic [15:0] cfg_def[3]  = '{16'h00FF, 16'h00FF, 16'h00FF};

  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, last_sample_cyc = 0;
  int          n_und = 0, n_fe = 0, n_spurious = 0;
  logic [15:0] rx_sb[$];
  logic [15:0] last_rx[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] mw[$], tw[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  always @(posedge sysClk) cyc++;

  // Monitor: pops the scoreboard on every rx_valid strobe and tallies the event strobes.
  initial begin
    logic [15:0] exp;
    forever begin
      @(posedge sysClk);
      #1;
      if (reset_n) begin
        if (rxv_m) begin
          if (rx_sb.size() == 0) begin
            n_checks++;
            $display("FAIL rx_unexpected: rx_valid with data %h, no word expected", rxd_m);
          end else begin
            exp = rx_sb.pop_front();
            check("rx_data", {16'h0, rxd_m}, {16'h0, exp});
            check("rx_latency", cyc - last_sample_cyc, SS + 2);
            last_rx[sel] = exp;
          end
        end
        if (und_m) n_und++;
        if (fe_m)  n_fe++;
        if (sel != 0 && (rxv0 || und0 || fe0)) n_spurious++;
        if (sel != 1 && (rxv1 || und1 || fe1)) n_spurious++;
        if (sel != 2 && (rxv2 || und2 || fe2)) n_spurious++;
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic feed_word(input logic [15:0] d);
    int t = 0;
    @(negedge sysClk);
    while (!txr_m && t < 2000) begin
      @(negedge sysClk);
      t++;
    end
    check("tx_ready_wait", {31'h0, txr_m}, 32'h1);
    if (txr_m) begin
      tx_data_tb  = d;
      tx_valid_tb = 1'b1;
      @(negedge sysClk);
      tx_valid_tb = 1'b0;
    end
  endtask

  // One frame of nwords master words (mw); tw is the TX stream offered to the slave.
  // Words are loaded at frame start and at each completed word; a missing word means DEFAULT_TX.
  task automatic run_frame(input int inst, input int nwords, input bit prebuf,
                           input int abort_bits, input bit rst_abort);
    int          w, complete, fi, shift, exp_und, s, nb, idx;
    logic [15:0] mask, mword, exp_w;
    logic [15:0] got[$];
    int          und_0, fe_0;
    w        = cfg_w[inst];
    mask     = (w == 16) ? 16'hFFFF : 16'h00FF;
    complete = (abort_bits > 0) ? nwords - 1 : nwords;
    shift    = prebuf ? 0 : 1;
    fi       = 0;
    sel      = inst;
    wait_n(2);
    und_0 = n_und;
    fe_0  = n_fe;
    if (prebuf && tw.size() > 0) begin
      feed_word(tw[0]);
      fi = 1;
    end
    cs_base = 1'b0;
    wait_n(8);
    fork
      begin
        for (int j = 0; j < nwords; j++) begin
          nb    = (abort_bits > 0 && j == nwords - 1) ? abort_bits : w;
          mword = '0;
          for (int i = 0; i < nb; i++) begin
            idx = cfg_lsb[inst] ? i : w - 1 - i;
            if (!cfg_cpha[inst]) begin
              mosi_pin = mw[j][idx];
              wait_n(H);
              sclk_base = 1'b1;
            end else begin
              sclk_base = 1'b1;
              mosi_pin  = mw[j][idx];
              wait_n(H);
              sclk_base = 1'b0;
            end
            last_sample_cyc = cyc;
            mword[idx]      = miso_m;
            if (i == w - 1) rx_sb.push_back(mw[j] & mask);
            wait_n(H);
            sclk_base = 1'b0;
          end
          if (nb == w) got.push_back(mword);
        end
      end
      begin
        if (!prebuf) wait_n(20);
        for (int k = fi; k < tw.size(); k++) feed_word(tw[k] & mask);
      end
    join
    wait_n(H);
    if (rst_abort) begin
      reset_n = 1'b0;
      #1;
      check("rst_miso", {31'h0, miso_m}, 32'h0);
      check("rst_miso_oe", {31'h0, oe_m}, 32'h0);
      check("rst_tx_ready", {31'h0, txr_m}, 32'h1);
      check("rst_rx_data", {16'h0, rxd_m}, 32'h0);
      check("rst_rx_valid", {31'h0, rxv_m}, 32'h0);
      wait_n(2);
      cs_base = 1'b1;
      wait_n(4);
      for (int k = 0; k < 3; k++) last_rx[k] = '0;
      reset_n = 1'b1;
      wait_n(4);
    end else begin
      cs_base = 1'b1;
      wait_n(8);
      check("idle_miso_oe", {31'h0, oe_m}, 32'h0);
      check("idle_miso", {31'h0, miso_m}, 32'h0);
    end
    exp_und = 0;
    for (s = 0; s <= complete; s++) begin
      if (s - shift >= 0 && s - shift < tw.size()) exp_w = tw[s - shift] & mask;
      else begin
        exp_w = cfg_def[inst];
        exp_und++;
      end
      if (s < complete && s < got.size()) check("miso_word", {16'h0, got[s]}, {16'h0, exp_w});
    end
    check("miso_word_count", got.size(), complete);
    if (!rst_abort) check("underrun_cnt", n_und - und_0, exp_und);
    check("frame_err_cnt", n_fe - fe_0, (abort_bits > 0 && !rst_abort) ? 1 : 0);
    check("rx_sb_drained", rx_sb.size(), 0);
    check("rx_data_hold", {16'h0, rxd_m}, {16'h0, last_rx[inst]});
    rx_sb.delete();
  endtask

  initial begin
    int inst, nw, ab, comp, ntx;
    wait_n(4);
    check("reset_tx_ready", {31'h0, txr_m}, 32'h1);
    check("reset_rx_data", {16'h0, rxd_m}, 32'h0);
    check("reset_miso_oe", {31'h0, oe_m}, 32'h0);
    check("reset_miso", {31'h0, miso_m}, 32'h0);
    reset_n = 1'b1;
    wait_n(4);
    check("post_reset_tx_ready", {31'h0, txr_m}, 32'h1);
    check("post_reset_rx_valid", {31'h0, rxv_m}, 32'h0);

    mw = '{16'h00A5}; tw = '{16'h0079};
    run_frame(0, 1, 1'b1, 0, 1'b0);

    mw = '{16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
    tw = '{16'h0079, 16'h0099, 16'h00E4, 16'($urandom_range(0, 255))};
    run_frame(1, 3, 1'b1, 0, 1'b0);

    mw = '{16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
    tw = '{16'($urandom_range(0, 255))};
    run_frame(0, 2, 1'b0, 0, 1'b0);

    mw = '{16'($urandom_range(0, 255))}; tw = '{16'($urandom_range(0, 255))};
    run_frame(0, 1, 1'b1, 5, 1'b0);

    mw = '{16'h1234}; tw = '{16'hBEEF};
    run_frame(2, 1, 1'b1, 0, 1'b0);

    mw = '{16'($urandom)}; tw = '{16'($urandom)};
    run_frame(2, 1, 1'b1, 7, 1'b1);

    mw = '{16'($urandom), 16'($urandom)}; tw = '{16'($urandom), 16'($urandom)};
    run_frame(2, 2, 1'b1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      inst = int'($urandom_range(0, 2));
      nw   = int'($urandom_range(1, 3));
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, cfg_w[inst] - 1)) : 0;
      comp = (ab > 0) ? nw - 1 : nw;
      ntx  = int'($urandom_range(0, comp + 1));
      mw.delete(); tw.delete();
      for (int k = 0; k < nw; k++) mw.push_back(16'($urandom));
      for (int k = 0; k < ntx; k++) tw.push_back(16'($urandom));
      run_frame(inst, nw, 1'b1, ab, 1'b0);
    end

    check("unselected_quiet", n_spurious, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
